// File: rtl/axi_lite_slave_interface.sv
// AXI4-Lite slave endpoint that turns AXI transactions into one-cycle register strobes for user logic.
// Independent write and read FSMs, base subtraction, range check with SLVERR, and a read-response timeout.
module axi_lite_slave_interface #(
    parameter int                              C_S_AXI_ADDR_WIDTH = 32,
    parameter int                              C_S_AXI_DATA_WIDTH = 32,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0]   C_S_AXI_BASE       = '0,
    parameter logic [C_S_AXI_ADDR_WIDTH-1:0]   C_S_AXI_ADDR_RANGE = C_S_AXI_ADDR_WIDTH'(32'h0000_1000),
    parameter int                              C_RD_TIMEOUT       = 255
) (
    input  logic                                ACLK,
    input  logic                                ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_AWADDR,
    input  logic [2:0]                          S_AXI_AWPROT,
    input  logic                                S_AXI_AWVALID,
    output logic                                S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]     S_AXI_WSTRB,
    input  logic                                S_AXI_WVALID,
    output logic                                S_AXI_WREADY,
    output logic [1:0]                          S_AXI_BRESP,
    output logic                                S_AXI_BVALID,
    input  logic                                S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]       S_AXI_ARADDR,
    input  logic [2:0]                          S_AXI_ARPROT,
    input  logic                                S_AXI_ARVALID,
    output logic                                S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       S_AXI_RDATA,
    output logic [1:0]                          S_AXI_RRESP,
    output logic                                S_AXI_RVALID,
    input  logic                                S_AXI_RREADY,
    output logic                                wr_en,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]       wr_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]       wr_data,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]     wr_strb,
    output logic                                rd_en,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]       rd_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]       rd_data,
    input  logic                                rd_valid
);

    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;
    localparam int CW = (C_RD_TIMEOUT < 2) ? 1 : $clog2(C_RD_TIMEOUT + 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_EXEC = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_REQ = 2'd1, R_WAIT = 2'd2, R_RESP = 2'd3} r_state_t;

    w_state_t          w_state_r;
    r_state_t          r_state_r;
    logic              awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
    logic [1:0]        bresp_r, rresp_r;
    logic              aw_held_r, w_held_r;
    logic [AW-1:0]     aw_off_r;
    logic [DW-1:0]     wdata_r, rdata_r;
    logic [SW-1:0]     wstrb_r;
    logic              wr_en_r, rd_en_r;
    logic [AW-1:0]     wr_addr_r, rd_addr_r;
    logic [DW-1:0]     wr_data_r;
    logic [SW-1:0]     wr_strb_r;
    logic [CW-1:0]     rd_cnt_r;

    logic              aw_hs_s, w_hs_s, ar_hs_s, aw_got_s, w_got_s, rd_timeout_s;
    logic [AW-1:0]     aw_off_s, ar_off_s, waddr_sel_s;
    logic [DW-1:0]     wdata_sel_s;
    logic [SW-1:0]     wstrb_sel_s;
    logic              unused_s;

    // Protection bits carry no meaning for this register bus.
    assign unused_s = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    // Offsets wrap modulo 2^AW, so addresses below the base land far out of range.
    assign aw_off_s     = S_AXI_AWADDR - C_S_AXI_BASE;
    assign ar_off_s     = S_AXI_ARADDR - C_S_AXI_BASE;
    assign aw_hs_s      = S_AXI_AWVALID & awready_r;
    assign w_hs_s       = S_AXI_WVALID & wready_r;
    assign ar_hs_s      = S_AXI_ARVALID & arready_r;
    assign aw_got_s     = aw_held_r | aw_hs_s;
    assign w_got_s      = w_held_r | w_hs_s;
    assign waddr_sel_s  = aw_held_r ? aw_off_r : aw_off_s;
    assign wdata_sel_s  = w_held_r ? wdata_r : S_AXI_WDATA;
    assign wstrb_sel_s  = w_held_r ? wstrb_r : S_AXI_WSTRB;
    assign rd_timeout_s = (rd_cnt_r == CW'(C_RD_TIMEOUT - 1));

    // Write FSM: collect AW and W in either order, strobe user write once, return B response.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b1;
            wready_r  <= 1'b1;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            aw_off_r  <= '0;
            wdata_r   <= '0;
            wstrb_r   <= '0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= '0;
            wr_strb_r <= '0;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    if (aw_got_s && w_got_s) begin
                        w_state_r <= W_EXEC;
                        wr_en_r   <= (waddr_sel_s < C_S_AXI_ADDR_RANGE);
                        wr_addr_r <= waddr_sel_s;
                        wr_data_r <= wdata_sel_s;
                        wr_strb_r <= wstrb_sel_s;
                        awready_r <= 1'b0;
                        wready_r  <= 1'b0;
                        aw_held_r <= 1'b0;
                        w_held_r  <= 1'b0;
                    end else begin
                        if (aw_hs_s) begin
                            aw_held_r <= 1'b1;
                            aw_off_r  <= aw_off_s;
                        end
                        if (w_hs_s) begin
                            w_held_r <= 1'b1;
                            wdata_r  <= S_AXI_WDATA;
                            wstrb_r  <= S_AXI_WSTRB;
                        end
                        awready_r <= ~aw_got_s;
                        wready_r  <= ~w_got_s;
                    end
                end
                W_EXEC: begin
                    wr_en_r   <= 1'b0;
                    bvalid_r  <= 1'b1;
                    bresp_r   <= wr_en_r ? RESP_OKAY : RESP_SLVERR;
                    w_state_r <= W_RESP;
                end
                W_RESP: begin
                    if (S_AXI_BREADY) begin
                        bvalid_r  <= 1'b0;
                        bresp_r   <= RESP_OKAY;
                        awready_r <= 1'b1;
                        wready_r  <= 1'b1;
                        w_state_r <= W_IDLE;
                    end
                end
                default: begin
                    w_state_r <= W_IDLE;
                    wr_en_r   <= 1'b0;
                    bvalid_r  <= 1'b0;
                    awready_r <= 1'b1;
                    wready_r  <= 1'b1;
                end
            endcase
        end
    end

    // Read FSM: strobe user read, wait for rd_valid or timeout, hold R response until RREADY.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b1;
            rvalid_r  <= 1'b0;
            rresp_r   <= RESP_OKAY;
            rdata_r   <= '0;
            rd_en_r   <= 1'b0;
            rd_addr_r <= '0;
            rd_cnt_r  <= '0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        arready_r <= 1'b0;
                        rd_addr_r <= ar_off_s;
                        rd_en_r   <= (ar_off_s < C_S_AXI_ADDR_RANGE);
                        rd_cnt_r  <= '0;
                        r_state_r <= R_REQ;
                    end
                end
                R_REQ, R_WAIT: begin
                    rd_en_r <= 1'b0;
                    // rd_en_r is still high during R_REQ exactly when the offset was in range.
                    if ((r_state_r == R_REQ) && !rd_en_r) begin
                        rvalid_r  <= 1'b1;
                        rresp_r   <= RESP_SLVERR;
                        rdata_r   <= '0;
                        r_state_r <= R_RESP;
                    end else if (rd_valid) begin
                        rvalid_r  <= 1'b1;
                        rresp_r   <= RESP_OKAY;
                        rdata_r   <= rd_data;
                        r_state_r <= R_RESP;
                    end else if (rd_timeout_s) begin
                        rvalid_r  <= 1'b1;
                        rresp_r   <= RESP_SLVERR;
                        rdata_r   <= '0;
                        r_state_r <= R_RESP;
                    end else begin
                        rd_cnt_r  <= rd_cnt_r + CW'(1);
                        r_state_r <= R_WAIT;
                    end
                end
                R_RESP: begin
                    if (S_AXI_RREADY) begin
                        rvalid_r  <= 1'b0;
                        arready_r <= 1'b1;
                        r_state_r <= R_IDLE;
                    end
                end
                default: begin
                    r_state_r <= R_IDLE;
                    rd_en_r   <= 1'b0;
                    rvalid_r  <= 1'b0;
                    arready_r <= 1'b1;
                end
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RRESP   = rresp_r;
    assign S_AXI_RDATA   = rdata_r;
    assign wr_en         = wr_en_r;
    assign wr_addr       = wr_addr_r;
    assign wr_data       = wr_data_r;
    assign wr_strb       = wr_strb_r;
    assign rd_en         = rd_en_r;
    assign rd_addr       = rd_addr_r;

endmodule

// File: tb/tb_axi_lite_slave_interface.sv
// Directed and randomized-handshake bench for axi_lite_slave_interface (RANGE 0x1000, timeout 8).
module tb_axi_lite_slave_interface;

    localparam int TO = 8;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [31:0] S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [31:0] S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        rd_en;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int wr_en_seen = 0;
    int rd_en_seen = 0;

    always #5 ACLK = ~ACLK;

    axi_lite_slave_interface #(
        .C_S_AXI_ADDR_WIDTH (32),
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_BASE       (32'h0000_0000),
        .C_S_AXI_ADDR_RANGE (32'h0000_1000),
        .C_RD_TIMEOUT       (TO)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    // Count user strobes to prove each transaction produces exactly one access.
    always @(posedge ACLK) begin
        if (wr_en === 1'b1) wr_en_seen++;
        if (rd_en === 1'b1) rd_en_seen++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        S_AXI_AWADDR = 32'h0; S_AXI_AWPROT = 3'b000; S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'h0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        S_AXI_ARADDR = 32'h0; S_AXI_ARPROT = 3'b000; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
        rd_data = 32'h0; rd_valid = 1'b0;
        repeat (3) tick();
        chk_cnt++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, wr_en, rd_en} !== 7'b1110000)
            $display("FAIL reset_ctrl: got %b want %b",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID, wr_en, rd_en}, 7'b1110000);
        else pass_cnt++;
        chk_cnt++;
        if ({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, wr_addr, wr_data, wr_strb, rd_addr} !== 136'h0)
            $display("FAIL reset_data: got %h want 0",
                     {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, wr_addr, wr_data, wr_strb, rd_addr});
        else pass_cnt++;
        ARESETN = 1'b1;
        tick();
    endtask

    task automatic test_write_same_cycle();
        S_AXI_AWADDR = 32'h10; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'hDEAD_BEEF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        chk_cnt++;
        if ({wr_en, wr_addr, wr_data, wr_strb} !== {1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF})
            $display("FAIL wr_same_strobe: got %h want %h", {wr_en, wr_addr, wr_data, wr_strb},
                     {1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF});
        else pass_cnt++;
        chk_cnt++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID} !== 3'b000)
            $display("FAIL wr_same_exec_ready: got %b want 000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID});
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({wr_en, S_AXI_BVALID, S_AXI_BRESP} !== 4'b0100)
            $display("FAIL wr_same_bresp: got %b want 0100", {wr_en, S_AXI_BVALID, S_AXI_BRESP});
        else pass_cnt++;
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        chk_cnt++;
        if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b011)
            $display("FAIL wr_same_done: got %b want 011", {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY});
        else pass_cnt++;
    endtask

    task automatic test_write_split(input bit aw_first);
        int n0 = wr_en_seen;
        bit ok = 1'b1;
        logic [2:0] exp_rdy = aw_first ? 3'b010 : 3'b100;
        S_AXI_AWADDR = 32'h24; S_AXI_WDATA = 32'hCAFE_F00D; S_AXI_WSTRB = 4'h3;
        if (aw_first) S_AXI_AWVALID = 1'b1; else S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        chk_cnt++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, wr_en} !== exp_rdy)
            $display("FAIL wr_split_first(aw_first=%0d): got %b want %b", aw_first,
                     {S_AXI_AWREADY, S_AXI_WREADY, wr_en}, exp_rdy);
        else pass_cnt++;
        tick();
        tick();
        if (aw_first) S_AXI_WVALID = 1'b1; else S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        chk_cnt++;
        if ({wr_en, wr_addr, wr_data, wr_strb} !== {1'b1, 32'h24, 32'hCAFE_F00D, 4'h3})
            $display("FAIL wr_split_strobe(aw_first=%0d): got %h want %h", aw_first,
                     {wr_en, wr_addr, wr_data, wr_strb}, {1'b1, 32'h24, 32'hCAFE_F00D, 4'h3});
        else pass_cnt++;
        tick();
        repeat (5) begin
            if ({S_AXI_BVALID, S_AXI_BRESP} !== 3'b100) ok = 1'b0;
            tick();
        end
        chk_cnt++;
        if (!ok || {S_AXI_BVALID, S_AXI_BRESP} !== 3'b100)
            $display("FAIL wr_split_bhold(aw_first=%0d): got %b want 100 held", aw_first,
                     {S_AXI_BVALID, S_AXI_BRESP});
        else pass_cnt++;
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        chk_cnt++;
        if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b011 || (wr_en_seen - n0) != 1)
            $display("FAIL wr_split_done(aw_first=%0d): bvalid/rdy %b want 011, wr_en count %0d want 1",
                     aw_first, {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, wr_en_seen - n0);
        else pass_cnt++;
    endtask

    task automatic test_read();
        bit ok = 1'b1;
        S_AXI_ARADDR = 32'h20; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        chk_cnt++;
        if ({rd_en, rd_addr, S_AXI_ARREADY} !== {1'b1, 32'h20, 1'b0})
            $display("FAIL rd_strobe: got %h want %h", {rd_en, rd_addr, S_AXI_ARREADY}, {1'b1, 32'h20, 1'b0});
        else pass_cnt++;
        rd_valid = 1'b1; rd_data = 32'h1234_5678;
        tick();
        rd_valid = 1'b0; rd_data = 32'h0;
        chk_cnt++;
        if ({S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, rd_en} !== {1'b1, 32'h1234_5678, 2'b00, 1'b0})
            $display("FAIL rd_resp: got %h want %h", {S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP, rd_en},
                     {1'b1, 32'h1234_5678, 2'b00, 1'b0});
        else pass_cnt++;
        repeat (3) begin
            tick();
            if ({S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP} !== {1'b1, 32'h1234_5678, 2'b00}) ok = 1'b0;
        end
        chk_cnt++;
        if (!ok) $display("FAIL rd_hold: got %h want %h", {S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP},
                          {1'b1, 32'h1234_5678, 2'b00});
        else pass_cnt++;
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        chk_cnt++;
        if ({S_AXI_RVALID, S_AXI_ARREADY} !== 2'b01)
            $display("FAIL rd_done: got %b want 01", {S_AXI_RVALID, S_AXI_ARREADY});
        else pass_cnt++;
        // Last in-range word, data arriving two cycles late.
        S_AXI_ARADDR = 32'hFFC; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        chk_cnt++;
        if ({rd_en, rd_addr} !== {1'b1, 32'hFFC})
            $display("FAIL rd_edge_strobe: got %h want %h", {rd_en, rd_addr}, {1'b1, 32'hFFC});
        else pass_cnt++;
        tick();
        tick();
        chk_cnt++;
        if (S_AXI_RVALID !== 1'b0) $display("FAIL rd_wait_early: got %b want 0", S_AXI_RVALID);
        else pass_cnt++;
        rd_valid = 1'b1; rd_data = 32'hA5A5_5A5A;
        tick();
        rd_valid = 1'b0; rd_data = 32'h0;
        chk_cnt++;
        if ({S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP} !== {1'b1, 32'hA5A5_5A5A, 2'b00})
            $display("FAIL rd_wait_resp: got %h want %h", {S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP},
                     {1'b1, 32'hA5A5_5A5A, 2'b00});
        else pass_cnt++;
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic test_out_of_range();
        int w0 = wr_en_seen;
        int r0 = rd_en_seen;
        S_AXI_AWADDR = 32'h1000; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h1111_1111; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        S_AXI_ARADDR = 32'h1000; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        chk_cnt++;
        if ({wr_en, rd_en} !== 2'b00) $display("FAIL oor_strobe: got %b want 00", {wr_en, rd_en});
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({S_AXI_BVALID, S_AXI_BRESP} !== 3'b110)
            $display("FAIL oor_bresp: got %b want 110", {S_AXI_BVALID, S_AXI_BRESP});
        else pass_cnt++;
        chk_cnt++;
        if ({S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA} !== {1'b1, 2'b10, 32'h0})
            $display("FAIL oor_rresp: got %h want %h", {S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA},
                     {1'b1, 2'b10, 32'h0});
        else pass_cnt++;
        S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        chk_cnt++;
        if ((wr_en_seen - w0) != 0 || (rd_en_seen - r0) != 0 || {S_AXI_BVALID, S_AXI_RVALID} !== 2'b00)
            $display("FAIL oor_no_access: wr_en %0d rd_en %0d valids %b want 0 0 00",
                     wr_en_seen - w0, rd_en_seen - r0, {S_AXI_BVALID, S_AXI_RVALID});
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        bit ok = 1'b1;
        S_AXI_ARADDR = 32'h40; S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        chk_cnt++;
        if (rd_en !== 1'b1) $display("FAIL to_strobe: got %b want 1", rd_en);
        else pass_cnt++;
        // The request cycle counts as the first of TO waiting cycles.
        repeat (TO - 1) begin
            tick();
            if (S_AXI_RVALID !== 1'b0) ok = 1'b0;
        end
        chk_cnt++;
        if (!ok) $display("FAIL to_early: RVALID rose before %0d cycles", TO);
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA} !== {1'b1, 2'b10, 32'h0})
            $display("FAIL to_resp: got %h want %h", {S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA},
                     {1'b1, 2'b10, 32'h0});
        else pass_cnt++;
        rd_valid = 1'b1; rd_data = 32'hFFFF_FFFF;
        tick();
        rd_valid = 1'b0; rd_data = 32'h0;
        chk_cnt++;
        if ({S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA} !== {1'b1, 2'b10, 32'h0})
            $display("FAIL to_late_ignored: got %h want %h", {S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA},
                     {1'b1, 2'b10, 32'h0});
        else pass_cnt++;
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
        rd_valid = 1'b1; rd_data = 32'h7777_7777;
        tick();
        rd_valid = 1'b0; rd_data = 32'h0;
        tick();
        chk_cnt++;
        if ({S_AXI_RVALID, S_AXI_ARREADY} !== 2'b01)
            $display("FAIL to_idle_ignored: got %b want 01", {S_AXI_RVALID, S_AXI_ARREADY});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int wdone = 0, rdone = 0, cyc = 0, exp_wr = 0, resp_dly = -1;
        int n0 = wr_en_seen;
        bit w_act = 1'b0, aw_pend = 1'b0, w_pend = 1'b0, r_act = 1'b0, ar_pend = 1'b0;
        bit aw_f, w_f, b_f, ar_f, r_f;
        logic [31:0] w_addr = 32'h0, w_dat = 32'h0, r_addr = 32'h0, r_exp;
        logic [3:0]  w_stb = 4'h0;
        while ((wdone < 100 || rdone < 100) && cyc < 20000) begin
            if (!w_act && wdone < 100) begin
                w_act = 1'b1; aw_pend = 1'b1; w_pend = 1'b1;
                w_addr = 32'($urandom_range(0, 32'h4FF)) << 2;
                w_dat  = $urandom;
                w_stb  = 4'($urandom_range(0, 15));
            end
            if (!r_act && rdone < 100) begin
                r_act = 1'b1; ar_pend = 1'b1;
                r_addr = 32'($urandom_range(0, 32'h4FF)) << 2;
            end
            if (aw_pend) begin
                S_AXI_AWADDR = w_addr;
                if (!S_AXI_AWVALID) S_AXI_AWVALID = 1'($urandom_range(0, 1));
            end
            if (w_pend) begin
                S_AXI_WDATA = w_dat; S_AXI_WSTRB = w_stb;
                if (!S_AXI_WVALID) S_AXI_WVALID = 1'($urandom_range(0, 1));
            end
            if (ar_pend) begin
                S_AXI_ARADDR = r_addr;
                if (!S_AXI_ARVALID) S_AXI_ARVALID = 1'($urandom_range(0, 1));
            end
            S_AXI_BREADY = 1'($urandom_range(0, 1));
            S_AXI_RREADY = 1'($urandom_range(0, 1));
            if (resp_dly == 0) begin
                rd_valid = 1'b1;
                rd_data  = {r_addr[15:0], ~r_addr[15:0]};
                resp_dly = -1;
            end else if (resp_dly > 0) begin
                resp_dly--;
            end
            aw_f = S_AXI_AWVALID && S_AXI_AWREADY;
            w_f  = S_AXI_WVALID && S_AXI_WREADY;
            b_f  = S_AXI_BVALID && S_AXI_BREADY;
            ar_f = S_AXI_ARVALID && S_AXI_ARREADY;
            r_f  = S_AXI_RVALID && S_AXI_RREADY;
            if (b_f) begin
                chk_cnt++;
                if (S_AXI_BRESP !== ((w_addr < 32'h1000) ? 2'b00 : 2'b10))
                    $display("FAIL b2b_bresp addr %h: got %b", w_addr, S_AXI_BRESP);
                else pass_cnt++;
                if (w_addr < 32'h1000) exp_wr++;
            end
            if (r_f) begin
                r_exp = (r_addr < 32'h1000) ? {r_addr[15:0], ~r_addr[15:0]} : 32'h0;
                chk_cnt++;
                if ({S_AXI_RRESP, S_AXI_RDATA} !== {((r_addr < 32'h1000) ? 2'b00 : 2'b10), r_exp})
                    $display("FAIL b2b_rresp addr %h: got %b/%h want data %h", r_addr, S_AXI_RRESP,
                             S_AXI_RDATA, r_exp);
                else pass_cnt++;
            end
            tick();
            cyc++;
            rd_valid = 1'b0;
            if (aw_f) begin aw_pend = 1'b0; S_AXI_AWVALID = 1'b0; end
            if (w_f)  begin w_pend = 1'b0;  S_AXI_WVALID = 1'b0;  end
            if (ar_f) begin ar_pend = 1'b0; S_AXI_ARVALID = 1'b0; end
            if (b_f)  begin w_act = 1'b0; wdone++; end
            if (r_f)  begin r_act = 1'b0; rdone++; end
            if (wr_en === 1'b1) begin
                chk_cnt++;
                if ({wr_addr, wr_data, wr_strb} !== {w_addr, w_dat, w_stb} || w_addr >= 32'h1000)
                    $display("FAIL b2b_wr_strobe: got %h/%h/%h want %h/%h/%h", wr_addr, wr_data, wr_strb,
                             w_addr, w_dat, w_stb);
                else pass_cnt++;
            end
            if (rd_en === 1'b1) begin
                chk_cnt++;
                if (rd_addr !== r_addr || r_addr >= 32'h1000)
                    $display("FAIL b2b_rd_strobe: got %h want %h", rd_addr, r_addr);
                else pass_cnt++;
                resp_dly = $urandom_range(0, 3);
            end
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
        S_AXI_BREADY = 1'b0; S_AXI_RREADY = 1'b0;
        chk_cnt++;
        if (wdone != 100 || rdone != 100 || (wr_en_seen - n0) != exp_wr)
            $display("FAIL b2b_totals: writes %0d reads %0d (want 100 100), wr_en %0d want %0d after %0d cycles",
                     wdone, rdone, wr_en_seen - n0, exp_wr, cyc);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid_resp();
        S_AXI_AWADDR = 32'h30; S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA = 32'h0BAD_F00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        tick();
        chk_cnt++;
        if (S_AXI_BVALID !== 1'b1) $display("FAIL rst_pre_bvalid: got %b want 1", S_AXI_BVALID);
        else pass_cnt++;
        #2;
        ARESETN = 1'b0;
        #1;
        chk_cnt++;
        if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, wr_en} !== 5'b01110)
            $display("FAIL rst_async: got %b want 01110",
                     {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, wr_en});
        else pass_cnt++;
        tick();
        ARESETN = 1'b1;
        S_AXI_AWADDR = 32'h34; S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        chk_cnt++;
        if ({wr_en, wr_addr} !== {1'b1, 32'h34})
            $display("FAIL rst_recover_strobe: got %h want %h", {wr_en, wr_addr}, {1'b1, 32'h34});
        else pass_cnt++;
        tick();
        chk_cnt++;
        if ({S_AXI_BVALID, S_AXI_BRESP} !== 3'b100)
            $display("FAIL rst_recover_bresp: got %b want 100", {S_AXI_BVALID, S_AXI_BRESP});
        else pass_cnt++;
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_same_cycle();
        test_write_split(1'b0);
        test_write_split(1'b1);
        test_read();
        test_out_of_range();
        test_timeout();
        test_back_to_back();
        test_reset_mid_resp();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
